// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD nibble sequencer.
// Holds the FSM state encoding and the long-settle command bytes.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STRB,
    HOLD,
    WAIT
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLR  = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME = 8'h02;

endpackage

// File: rtl/lcd_tick_gen.sv
// Tick divider: one-cycle tick_o each time the count reaches DIV-1.
// Ports: clk_i, rst_i (async, high), restart_i (sync clear), tick_o.
module lcd_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (restart_i || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // A restart cycle never produces a tick, so each phase is a full DIV.
  assign tick_o = (cnt == LAST) && !restart_i;

endmodule

// File: rtl/lcd_nib_seq.sv
// Pops {rsn, byte} words from the LCD FIFO and writes them to HD44780
// pins as two nibbles (high first) with setup/strobe/hold/settle timing.
// Ports: clk_i, rst_i (async, high); FIFO side rsn_i, data_i, rd_rdy_i,
// rd_o; pin side lcd_rs_o, lcd_data_o, lcd_e_o; status busy_o.
// Optional macro LCD_LONG_CMD_EN: clear/home commands settle LONG_TICKS.
module lcd_nib_seq
  import lcd_pkg::*;
#(
  parameter int LCD_W      = 4,
  parameter int CLK_HZ     = 160_000_000,
  parameter int LCD_HZ     = 1_000_000,
  parameter int WAIT_TICKS = 40,
  parameter int LONG_TICKS = 1600
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rsn_i,
  input  logic [2*LCD_W-1:0] data_i,
  input  logic               rd_rdy_i,
  output logic               rd_o,
  output logic               lcd_rs_o,
  output logic [LCD_W-1:0]   lcd_data_o,
  output logic               lcd_e_o,
  output logic               busy_o
);

  localparam int TICK_DIV = CLK_HZ / LCD_HZ;
  localparam int WMAX =
    (WAIT_TICKS > LONG_TICKS) ? WAIT_TICKS : LONG_TICKS;
  localparam int WW = $clog2(WMAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TICKS - 1);

  lcd_state_t state, state_n;

  logic             hi, hi_n;
  logic [LCD_W-1:0] lo_q;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic [WW-1:0]    wlast;
  logic             tick;
  logic             pop;
  logic             rs_n;
  logic             e_n;
  logic [LCD_W-1:0] data_n;

`ifdef LCD_LONG_CMD_EN
  localparam logic [WW-1:0] LONG_LAST = WW'(LONG_TICKS - 1);
  localparam logic [2*LCD_W-1:0] CLR_W = (2*LCD_W)'(LCD_CMD_CLR);
  localparam logic [2*LCD_W-1:0] HOME_W = (2*LCD_W)'(LCD_CMD_HOME);

  logic long_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      long_q <= 1'b0;
    end else if (pop) begin
      long_q <= rsn_i && (data_i == CLR_W || data_i == HOME_W);
    end
  end

  assign wlast = long_q ? LONG_LAST : WAIT_LAST;
`else
  assign wlast = WAIT_LAST;
`endif

  // Pop is a combinational grant from IDLE; reset blocks it outright.
  assign pop    = (state == IDLE) && rd_rdy_i && !rst_i;
  assign rd_o   = pop;
  assign busy_o = (state != IDLE);

  lcd_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .restart_i(pop),
    .tick_o   (tick)
  );

  always_comb begin
    state_n = state;
    hi_n    = hi;
    wcnt_n  = wcnt;
    rs_n    = lcd_rs_o;
    data_n  = lcd_data_o;
    unique case (state)
      IDLE: begin
        if (pop) begin
          state_n = SETUP;
          hi_n    = 1'b1;
          rs_n    = ~rsn_i;
          data_n  = data_i[2*LCD_W-1:LCD_W];
        end
      end
      SETUP: if (tick) state_n = STRB;
      STRB:  if (tick) state_n = HOLD;
      HOLD: begin
        if (tick) begin
          if (hi) begin
            state_n = SETUP;
            hi_n    = 1'b0;
            data_n  = lo_q;
          end else begin
            state_n = WAIT;
            wcnt_n  = '0;
          end
        end
      end
      WAIT: begin
        if (tick) begin
          if (wcnt == wlast) begin
            state_n = IDLE;
          end else begin
            wcnt_n = wcnt + WW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // E is registered off the next state so it is high exactly in STRB.
    e_n = (state_n == STRB);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      hi         <= 1'b1;
      wcnt       <= '0;
      lo_q       <= '0;
      lcd_rs_o   <= 1'b0;
      lcd_data_o <= '0;
      lcd_e_o    <= 1'b0;
    end else begin
      state      <= state_n;
      hi         <= hi_n;
      wcnt       <= wcnt_n;
      lcd_rs_o   <= rs_n;
      lcd_data_o <= data_n;
      lcd_e_o    <= e_n;
      if (pop) begin
        lo_q <= data_i[LCD_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_lcd_nib_seq.sv
// Self-checking bench for lcd_nib_seq (TICK_DIV=4, WAIT=3, LONG=10).
// Honors LCD_LONG_CMD_EN for the expected settle period.
module tb_lcd_nib_seq;

  localparam int TD = 4;
  localparam int WT = 3;
  localparam int LT = 10;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rsn_i;
  logic [7:0] data_i;
  logic       rd_rdy_i;
  logic       rd_o;
  logic       lcd_rs_o;
  logic [3:0] lcd_data_o;
  logic       lcd_e_o;
  logic       busy_o;

  int npass = 0;
  int ntot  = 0;

  logic [8:0] q[$];

  always #5 clk = ~clk;

  lcd_nib_seq #(
    .LCD_W     (4),
    .CLK_HZ    (4_000_000),
    .LCD_HZ    (1_000_000),
    .WAIT_TICKS(WT),
    .LONG_TICKS(LT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .rsn_i     (rsn_i),
    .data_i    (data_i),
    .rd_rdy_i  (rd_rdy_i),
    .rd_o      (rd_o),
    .lcd_rs_o  (lcd_rs_o),
    .lcd_data_o(lcd_data_o),
    .lcd_e_o   (lcd_e_o),
    .busy_o    (busy_o)
  );

  task automatic ck(input string tag, input logic [15:0] got,
                    input logic [15:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] pins();
    return {rd_o, lcd_rs_o, lcd_data_o, lcd_e_o, busy_o};
  endfunction

  // FIFO model: show-ahead head word on the inputs whenever non-empty.
  task automatic drive();
    if (q.size() > 0) begin
      rd_rdy_i = 1'b1;
      {rsn_i, data_i} = q[0];
    end else begin
      rd_rdy_i = 1'b0;
      {rsn_i, data_i} = 9'($urandom);
    end
  endtask

  function automatic int period(input logic [8:0] w);
    bit lng;
    lng = 1'b0;
`ifdef LCD_LONG_CMD_EN
    lng = w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02);
`endif
    return 1 + (6 + (lng ? LT : WT)) * TD;
  endfunction

  // Pins k cycles after the pop: three tick-long phases per nibble
  // (setup, strobe, hold), then settle with the low nibble held.
  function automatic logic [7:0] expv(input logic [8:0] w, input int k);
    int ph;
    logic [3:0] nib;
    logic e;
    ph  = (k - 1) / TD;
    nib = (ph < 3) ? w[7:4] : w[3:0];
    e   = (ph == 1 || ph == 4);
    return {1'b0, ~w[8], nib, e, 1'b1};
  endfunction

  // Called at the falling edge of the cycle where a pop is expected.
  task automatic txn(input int abort_k = 0);
    logic [8:0] w;
    int p;
    ck("pop", 16'(rd_o), 16'(1));
    w = q[0];
    p = period(w);
    @(posedge clk);
    #1;
    void'(q.pop_front());
    drive();
    for (int k = 1; k < p; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        #2 rst_i = 1'b1;
        #1 ck("abort_pins", 16'(pins()), 16'(0));
        @(posedge clk);
        #1 rst_i = 1'b0;
        drive();
        @(negedge clk);
        return;
      end
      ck($sformatf("pins w=%h k=%0d", w, k), 16'(pins()),
         16'(expv(w, k)));
    end
    @(negedge clk);
    ck("idle_busy", 16'(busy_o), 16'(0));
    ck("next_pop", 16'(rd_o), 16'(q.size() > 0));
  endtask

  task automatic start(input logic [8:0] w);
    @(posedge clk);
    #1;
    q.push_back(w);
    drive();
    @(negedge clk);
  endtask

  initial begin
    // Reset with a word waiting: nothing pops, every output low.
    rst_i = 1'b1;
    q.push_back({1'b0, 8'hA5});
    drive();
    repeat (2) @(negedge clk);
    ck("reset_pins", 16'(pins()), 16'(0));
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);

    // Single data word.
    txn();

    // Three words back to back.
    @(posedge clk);
    #1;
    q.push_back({1'b0, 8'h12});
    q.push_back({1'b1, 8'hF0});
    q.push_back({1'b0, 8'h6E});
    drive();
    @(negedge clk);
    repeat (3) txn();

    // Clear, home and an ordinary command.
    start({1'b1, 8'h01});
    txn();
    start({1'b1, 8'h38});
    txn();
    start({1'b1, 8'h02});
    txn();
    start({1'b0, 8'h01});
    txn();

    // Reset in the second strobe, then a clean restart.
    @(posedge clk);
    #1;
    q.push_back({1'b0, 8'h3C});
    q.push_back({1'b0, 8'hC3});
    drive();
    @(negedge clk);
    txn(18);
    txn();

    // Randomized batches with idle gaps.
    repeat (12) begin
      int gap;
      int n;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        ck("idle", 16'({rd_o, busy_o}), 16'(0));
      end
      n = $urandom_range(1, 3);
      @(posedge clk);
      #1;
      repeat (n) begin
        if ($urandom_range(0, 3) == 0)
          q.push_back({1'b1, 7'b0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1))});
        else
          q.push_back(9'($urandom));
      end
      drive();
      @(negedge clk);
      while (q.size() > 0) txn();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
